// File: rtl/pe_ctrl.sv
// Tile sequencer for one SD4 PE running a 3x3 convolution: requests image
// columns, gates the PE clock enable and tags each MAC result with its (row, col).
module pe_ctrl #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int MAC_LAT = 2,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [35:0]      cfg_weight,
  input  logic [4:0]       cfg_exp_bias,
  output logic             busy,
  output logic             done,
  output logic             col_req,
  input  logic             col_vld,
  input  logic [23:0]      col_data,
  output logic [23:0]      pe_image_in,
  output logic [35:0]      pe_weight,
  output logic [4:0]       pe_exp_bias,
  output logic             pe_en,
  output logic             out_vld,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  input  logic             out_rdy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Stage 0 tracks the PE img_buff register, stages 1..MAC_LAT its MAC registers.
  localparam int DEPTH = MAC_LAT + 1;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(IMG_H - 3);
  localparam logic [CNT_W-1:0] TAG_OFS   = CNT_W'(2);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] row, col;
  logic [DEPTH-1:0] tag_vld;
  logic [CNT_W-1:0] tag_row [DEPTH];
  logic [CNT_W-1:0] tag_col [DEPTH];

  logic in_stream, adv, consume, pipe_busy;

  assign out_vld = tag_vld[DEPTH-1];
  assign out_row = tag_row[DEPTH-1];
  assign out_col = tag_col[DEPTH-1];

  assign in_stream   = (state == S_FILL) || (state == S_RUN);
  assign adv         = !out_vld || out_rdy;
  assign col_req     = in_stream && adv;
  assign consume     = col_req && col_vld;
  assign pe_en       = consume || ((state == S_DRAIN) && adv);
  assign pe_image_in = (state == S_IDLE) ? '0 : col_data;
  assign busy        = in_stream || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  // Results still in flight ahead of the output stage.
  assign pipe_busy   = |tag_vld[DEPTH-2:0];

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if (consume && col == FILL_LAST) state_nxt = S_RUN;
      S_RUN:   if (consume && col == LAST_COL)
                 state_nxt = (row == LAST_ROW) ? S_DRAIN : S_FILL;
      S_DRAIN: if (!pipe_busy && adv) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      pe_weight   <= '0;
      pe_exp_bias <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        pe_weight   <= cfg_weight;
        pe_exp_bias <= cfg_exp_bias;
        row         <= '0;
        col         <= '0;
      end else if (consume) begin
        if (col == LAST_COL) begin
          col <= '0;
          if (row != LAST_ROW) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // NOTE: the tag pipe is reset explicitly because out_vld must drop the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_row[i] <= '0;
        tag_col[i] <= '0;
      end
    end else if (pe_en) begin
      // FILL columns and DRAIN cycles shift in a bubble.
      tag_vld    <= {tag_vld[DEPTH-2:0], consume && (state == S_RUN)};
      tag_row[0] <= row;
      tag_col[0] <= col - TAG_OFS;
      for (int i = 1; i < DEPTH; i++) begin
        tag_row[i] <= tag_row[i-1];
        tag_col[i] <= tag_col[i-1];
      end
    end else if (out_vld && out_rdy) begin
      // Transferred while the source stalls: retire it so it is not presented twice.
      tag_vld[DEPTH-1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// Self-checking bench for pe_ctrl: a 5x4 tile instance driven through normal,
// bubble, backpressure, busy-start and reset cases, plus a 3x3 boundary instance.
module tb_pe_ctrl;

  localparam int W   = 5;
  localparam int H   = 4;
  localparam int LAT = 2;
  localparam int CW  = 6;
  localparam int N_RES  = (H - 2) * (W - 2);
  localparam int N_COLS = (H - 2) * W;
  localparam int BASE_CYC = 1 + N_COLS + LAT + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, busy, done, col_req, col_vld, pe_en, out_vld, out_rdy;
  logic [35:0]   cfg_weight, pe_weight;
  logic [4:0]    cfg_exp_bias, pe_exp_bias;
  logic [23:0]   col_data, pe_image_in;
  logic [CW-1:0] out_row, out_col;

  logic          b_start, b_busy, b_done, b_col_req, b_col_vld, b_pe_en, b_out_vld, b_out_rdy;
  logic [35:0]   b_cfg_weight, b_pe_weight;
  logic [4:0]    b_cfg_exp_bias, b_pe_exp_bias;
  logic [23:0]   b_col_data, b_pe_image_in;
  logic [CW-1:0] b_out_row, b_out_col;

  pe_ctrl #(.IMG_W(W), .IMG_H(H), .MAC_LAT(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cfg_weight(cfg_weight),
    .cfg_exp_bias(cfg_exp_bias), .busy(busy), .done(done), .col_req(col_req),
    .col_vld(col_vld), .col_data(col_data), .pe_image_in(pe_image_in),
    .pe_weight(pe_weight), .pe_exp_bias(pe_exp_bias), .pe_en(pe_en),
    .out_vld(out_vld), .out_row(out_row), .out_col(out_col), .out_rdy(out_rdy)
  );

  pe_ctrl #(.IMG_W(3), .IMG_H(3), .MAC_LAT(LAT), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst(rst), .start(b_start), .cfg_weight(b_cfg_weight),
    .cfg_exp_bias(b_cfg_exp_bias), .busy(b_busy), .done(b_done), .col_req(b_col_req),
    .col_vld(b_col_vld), .col_data(b_col_data), .pe_image_in(b_pe_image_in),
    .pe_weight(b_pe_weight), .pe_exp_bias(b_pe_exp_bias), .pe_en(b_pe_en),
    .out_vld(b_out_vld), .out_row(b_out_row), .out_col(b_out_col), .out_rdy(b_out_rdy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cols_seen, res_seen, done_seen;
  logic [11:0] exp_q[$];
  logic [11:0] exp_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every transferred result must match the next expected raster tag.
  always @(negedge clk) begin
    if (out_vld && out_rdy) begin
      res_seen++;
      if (exp_q.size() == 0) begin
        check("sb_extra", {1'b0, out_row, out_col}, 13'h1000);
      end else begin
        exp_tag = exp_q.pop_front();
        check("sb_tag", {out_row, out_col}, exp_tag);
      end
    end
    if (col_req && col_vld) cols_seen++;
    if (done) done_seen++;
  end

  // mode 0 basic, 1 source bubbles, 2 backpressure at (0,1), 3 start while busy
  task automatic run_tile(input int mode, input int exp_cyc);
    int n;
    bit fin;
    exp_q.delete();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        exp_q.push_back({6'(r), 6'(c)});
    cols_seen = 0; res_seen = 0; done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_weight = 36'h123456789; cfg_exp_bias = 5'd15;
    col_vld = 1'b1; out_rdy = 1'b1;
    n = 0; fin = 1'b0;
    while (!fin && n < 200) begin
      @(posedge clk); #1;
      n++;
      start        = (mode == 3 && n == 5);
      cfg_weight   = 36'h0;
      cfg_exp_bias = 5'd0;
      col_data     = 24'($urandom);
      col_vld      = (mode == 1) ? n[0] : 1'b1;
      out_rdy      = !(mode == 2 && n >= 7 && n <= 10);
      @(negedge clk);
      if (n == 2) check("img_pass", pe_image_in, col_data);
      if (n == 6) check("weight_mid", {pe_weight, pe_exp_bias}, {36'h123456789, 5'd15});
      if (mode == 1 && !col_vld && n < 2 * N_COLS) check("bubble_pe_en", pe_en, 1'b0);
      if (mode == 2 && n >= 7 && n <= 10)
        check("stall_hold", {out_vld, out_row, out_col, col_req, pe_en},
              {1'b1, 6'd0, 6'd1, 1'b0, 1'b0});
      if (done) fin = 1'b1;
    end
    check("done_seen_in_time", fin, 1'b1);
    check("tile_cycles", n, exp_cyc);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", {done, busy}, 2'b00);
    check("cols_consumed", cols_seen, N_COLS);
    check("results", res_seen, N_RES);
    check("sb_empty", exp_q.size(), 0);
    check("done_pulses", done_seen, 1);
    check("weight_end", {pe_weight, pe_exp_bias}, {36'h123456789, 5'd15});
  endtask

  task automatic reset_mid_tile();
    cols_seen = 0; res_seen = 0; done_seen = 0;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1; cfg_weight = 36'h123456789; cfg_exp_bias = 5'd15;
    col_vld = 1'b1; out_rdy = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      col_data = 24'h5a5a5a;
    end
    // Cycle 6: row 1 FILL with result (0,0) on the output.
    check("pre_rst_vld", {out_vld, out_row, out_col}, {1'b1, 6'd0, 6'd0});
    rst = 1'b0;
    #1;
    check("rst_outs", {busy, done, col_req, pe_en, out_vld, out_row, out_col}, '0);
    check("rst_cfg", {pe_weight, pe_exp_bias}, '0);
    check("rst_img", pe_image_in, 24'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("rst_no_done", {done_seen[7:0], busy}, 9'h0);
  endtask

  task automatic boundary_tile();
    int n, b_cols, b_res;
    bit fin;
    b_cols = 0; b_res = 0; n = 0; fin = 1'b0;
    @(posedge clk); #1;
    b_start = 1'b1; b_cfg_weight = 36'hfedcba987; b_cfg_exp_bias = 5'd3;
    b_col_vld = 1'b1; b_out_rdy = 1'b1;
    while (!fin && n < 100) begin
      @(posedge clk); #1;
      n++;
      b_start = 1'b0;
      b_col_data = 24'($urandom);
      @(negedge clk);
      if (b_col_req && b_col_vld) b_cols++;
      if (b_out_vld) begin
        b_res++;
        check("b_tag", {b_out_row, b_out_col}, 12'h000);
      end
      if (b_done) fin = 1'b1;
    end
    check("b_done_seen", fin, 1'b1);
    check("b_cycles", n, 1 + 3 + LAT + 1);
    check("b_cols", b_cols, 3);
    check("b_results", b_res, 1);
    check("b_weight", {b_pe_weight, b_pe_exp_bias}, {36'hfedcba987, 5'd3});
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; cfg_weight = '0; cfg_exp_bias = '0;
    col_vld = 1'b0; col_data = 24'habcdef; out_rdy = 1'b1;
    b_start = 1'b0; b_cfg_weight = '0; b_cfg_exp_bias = '0;
    b_col_vld = 1'b0; b_col_data = '0; b_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {busy, done, col_req, pe_en, out_vld, out_row, out_col}, '0);
    check("reset_cfg", {pe_weight, pe_exp_bias}, '0);
    check("reset_img", pe_image_in, 24'h0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    run_tile(0, BASE_CYC);
    run_tile(1, BASE_CYC + N_COLS - 1);
    run_tile(2, BASE_CYC + 4);
    run_tile(3, BASE_CYC);
    reset_mid_tile();
    run_tile(0, BASE_CYC);
    boundary_tile();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
